// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_unit
//  Purpose  : Multi-cycle radix-2 shift-add 32x32 multiplier (mult / multu)
//             with HI/LO result registers and mthi/mtlo write access.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW         = $clog2(WIDTH) + 1;
    localparam logic [4:0]     c_op_mult  = 5'b10010;
    localparam logic [4:0]     c_op_multu = 5'b10011;
    localparam logic [CW-1:0]  c_last     = CW'(WIDTH - 1);

    localparam logic [1:0]     c_idle     = 2'd0;
    localparam logic [1:0]     c_run      = 2'd1;
    localparam logic [1:0]     c_fix      = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_signed;
    logic               w_go;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    // Decode the request and form operand magnitudes. The magnitude of the most
    // negative value wraps to itself, which read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        w_is_signed = (alucontrol == c_op_mult);
        w_go        = start && ((alucontrol == c_op_mult) || (alucontrol == c_op_multu));
        w_mag_a     = (w_is_signed && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
        w_mag_b     = (w_is_signed && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;
    end

    // Sequencer: IDLE accepts requests and HI/LO writes, RUN adds one multiplier
    // bit per cycle, FIX applies the sign and commits the product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_idle;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (hi_we) r_hi <= wd;
                    if (lo_we) r_lo <= wd;
                    if (w_go) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= w_is_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= c_run;
                    end
                end
                c_run: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (r_count == c_last) r_state <= c_fix;
                end
                c_fix: begin
                    {r_hi, r_lo} <= r_neg ? (~r_acc + 1'b1) : r_acc;
                    r_done       <= 1'b1;
                    r_state      <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy = (r_state != c_idle);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_unit
//  Purpose  : Self-checking bench for mul_unit: directed vector table, hand
//             sequences for busy/reset corner cases, random vs. 64-bit model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_unit;

    localparam logic [4:0] c_mult  = 5'b10010;
    localparam logic [4:0] c_multu = 5'b10011;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t tbl[7];

    mul_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wd         (wd),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (op == c_mult) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for busy to drop; returns busy cycles.
    task automatic run_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cycles);
        start = 1'b1; alucontrol = op; srca = a; srcb = b;
        tick();
        start = 1'b0; alucontrol = 5'b0; srca = '0; srcb = '0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_low_while_busy", 64'(done), 64'd0);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        int          cyc;
        logic [63:0] exp;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0] = '{c_mult,  32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
        tbl[1] = '{c_mult,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[2] = '{c_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[3] = '{c_mult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tbl[4] = '{c_mult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[5] = '{c_multu, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        tbl[6] = '{c_mult,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};

        rst_n = 1'b0; start = 1'b0; alucontrol = '0; srca = '0; srcb = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        repeat (3) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed table; consecutive requests also start in the done cycle.
        for (int i = 0; i < 7; i++) begin
            run_mul(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
            check("tbl_busy_cycles", 64'(cyc), 64'd33);
            check("tbl_done_pulse", 64'(done), 64'd1);
            check("tbl_hilo", {hi, lo}, {tbl[i].eh, tbl[i].el});
        end
        tick();
        check("done_single_cycle", 64'(done), 64'd0);

        // Requests and mthi while busy are dropped; mtlo after done applies.
        start = 1'b1; alucontrol = c_mult; srca = 32'd2; srcb = 32'd3;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; srca = 32'd9; srcb = 32'd9; hi_we = 1'b1; wd = 32'hDEAD;
        tick();
        start = 1'b0; hi_we = 1'b0; alucontrol = '0;
        check("hi_we_dropped_busy", 64'(hi), 64'(tbl[6].eh));
        cyc = 0;
        while (!done && cyc < 100) begin cyc++; tick(); end
        check("busy_ignored_result", {hi, lo}, {32'h0, 32'h6});
        tick();
        check("no_queued_op", 64'(busy), 64'd0);
        lo_we = 1'b1; wd = 32'h1234;
        tick();
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h1234);
        check("mtlo_hi_kept", 64'(hi), 64'h0);

        // Async reset in the middle of RUN aborts with no partial write.
        start = 1'b1; alucontrol = c_mult; srca = 32'd5; srcb = 32'd5;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        run_mul(c_mult, 32'd4, 32'd4, cyc);
        check("post_reset_cycles", 64'(cyc), 64'd33);
        check("post_reset_hilo", {hi, lo}, 64'h10);
        tick();

        // Unsupported code: no busy, registers untouched.
        start = 1'b1; alucontrol = 5'b00010; srca = 32'd7; srcb = 32'd7;
        tick();
        start = 1'b0;
        check("bad_code_busy", 64'(busy), 64'd0);
        check("bad_code_hilo", {hi, lo}, 64'h10);

        // mthi with start in IDLE: write lands, then the product overwrites it.
        start = 1'b1; alucontrol = c_multu; srca = 32'd3; srcb = 32'd11;
        hi_we = 1'b1; wd = 32'hCAFE;
        tick();
        start = 1'b0; hi_we = 1'b0;
        check("mthi_with_start", 64'(hi), 64'hCAFE);
        check("mthi_busy", 64'(busy), 64'd1);
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; tick(); end
        check("mthi_overwritten", {hi, lo}, 64'd33);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 1) == 0) ? c_mult : c_multu;
            a  = $urandom;
            b  = $urandom;
            if (i % 8 == 0) a = 32'h80000000;
            if (i % 8 == 1) b = 32'hFFFFFFFF;
            if (i % 8 == 2) b = 32'h0;
            exp = ref_mul(op, a, b);
            run_mul(op, a, b, cyc);
            check("rand_cycles", 64'(cyc), 64'd33);
            check("rand_hilo", {hi, lo}, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
